// File: rtl/layer_mixer_pkg.sv
// Shared types and defaults for the layer mixer: fade state, parameter
// defaults and packed-colour channel extraction.
package layer_mixer_pkg;

    localparam int unsigned DEF_NUM_LAYERS = 5;
    localparam int unsigned DEF_COLOR_W    = 8;
    localparam int unsigned DEF_OVL_IDX    = 3;
    localparam int unsigned DEF_ALPHA_W    = 4;
    localparam int unsigned DEF_FADE_DIV   = 2;

    // Widest colour channel chan() can extract; pixels are widened to this.
    localparam int unsigned MAX_COLOR_W = 16;
    localparam int unsigned CHAN_IN_W   = 3 * MAX_COLOR_W;

    typedef enum logic [1:0] {
        OFF,
        FADE_IN,
        ON,
        FADE_OUT
    } fade_state_t;

    // Channel i of a packed {R,G,B} pixel of cw-bit channels (0 = B, 2 = R).
    function automatic logic [MAX_COLOR_W-1:0] chan(
        input logic [CHAN_IN_W-1:0] rgb,
        input int unsigned          i,
        input int unsigned          cw
    );
        logic [CHAN_IN_W-1:0]   sh;
        logic [MAX_COLOR_W-1:0] mask;
        sh   = rgb >> (i * cw);
        mask = MAX_COLOR_W'((32'd1 << cw) - 32'd1);
        return MAX_COLOR_W'(sh) & mask;
    endfunction

endpackage

// File: rtl/layer_mixer_prio_enc.sv
// Combinational priority encoder: highest active layer (win) and the
// highest active layer beneath it (und), each with a valid bit.
module layer_prio_enc
    import layer_mixer_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = DEF_NUM_LAYERS,
    localparam int unsigned IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic [NUM_LAYERS-1:0] act,
    output logic [IDX_W-1:0]      win,
    output logic                  win_valid,
    output logic [IDX_W-1:0]      und,
    output logic                  und_valid
);

    // Scan upward; each new hit demotes the previous winner to underlay.
    always_comb begin
        win       = '0;
        win_valid = 1'b0;
        und       = '0;
        und_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (act[i]) begin
                und       = win;
                und_valid = win_valid;
                win       = IDX_W'(i);
                win_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_mixer.sv
// Layer mixer: per-pixel priority select across NUM_LAYERS sources with an
// enable mask, frame-synchronous alpha fade of one overlay layer, and a
// 2-stage pipeline with syncs delayed to stay aligned.
module layer_mixer
    import layer_mixer_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int unsigned COLOR_W    = DEF_COLOR_W,
    parameter int unsigned OVL_IDX    = DEF_OVL_IDX,
    parameter int unsigned ALPHA_W    = DEF_ALPHA_W,
    parameter int unsigned FADE_DIV   = DEF_FADE_DIV
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            frame_start,
    input  logic                            pix_valid_in,
    input  logic                            hs_in,
    input  logic                            vs_in,
    input  logic [NUM_LAYERS-1:0]           rq_flag,
    input  logic [NUM_LAYERS-1:0]           layer_en,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0] rgb_in,
    input  logic                            ovl_req,
    output logic [3*COLOR_W-1:0]            rgb_out,
    output logic                            pix_valid_out,
    output logic                            hs_out,
    output logic                            vs_out,
    output logic                            fade_busy
);

    localparam int unsigned IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int unsigned PIX_W = 3 * COLOR_W;
    localparam int unsigned MIX_W = COLOR_W + ALPHA_W + 1;
    localparam int unsigned DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [ALPHA_W:0] ALPHA_MAX = {1'b1, {ALPHA_W{1'b0}}};
    localparam logic [ALPHA_W:0] ALPHA_ONE = {{ALPHA_W{1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(FADE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

    // ---------------- fade control ----------------
    fade_state_t      state, state_nx;
    logic [ALPHA_W:0] alpha, alpha_nx;
    logic [DIV_W-1:0] div_cnt, div_nx;
    logic             go_up, go_dn;

    // Fade state, alpha and frame divider registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= OFF;
            alpha   <= '0;
            div_cnt <= '0;
        end else begin
            state   <= state_nx;
            alpha   <= alpha_nx;
            div_cnt <= div_nx;
        end
    end

    // Fade next-state: only acts on frame_start. Entering a fade from rest
    // counts that frame toward the first step; a reversal restarts the divider
    // without moving alpha.
    always_comb begin
        state_nx = state;
        alpha_nx = alpha;
        div_nx   = div_cnt;
        go_up    = 1'b0;
        go_dn    = 1'b0;
        if (frame_start) begin
            unique case (state)
                OFF: go_up = ovl_req;
                FADE_IN: begin
                    if (ovl_req) begin
                        go_up = 1'b1;
                    end else begin
                        div_nx   = '0;
                        state_nx = (alpha == '0) ? OFF : FADE_OUT;
                    end
                end
                ON: go_dn = !ovl_req;
                FADE_OUT: begin
                    if (!ovl_req) begin
                        go_dn = 1'b1;
                    end else begin
                        div_nx   = '0;
                        state_nx = (alpha == ALPHA_MAX) ? ON : FADE_IN;
                    end
                end
                default: state_nx = OFF;
            endcase
        end
        if (go_up && alpha != ALPHA_MAX) begin
            state_nx = FADE_IN;
            if (div_cnt == DIV_LAST) begin
                div_nx   = '0;
                alpha_nx = alpha + ALPHA_ONE;
                if (alpha_nx == ALPHA_MAX) state_nx = ON;
            end else begin
                div_nx = div_cnt + DIV_ONE;
            end
        end
        if (go_dn && alpha != '0) begin
            state_nx = FADE_OUT;
            if (div_cnt == DIV_LAST) begin
                div_nx   = '0;
                alpha_nx = alpha - ALPHA_ONE;
                if (alpha_nx == '0) state_nx = OFF;
            end else begin
                div_nx = div_cnt + DIV_ONE;
            end
        end
    end

    assign fade_busy = (state == FADE_IN) || (state == FADE_OUT);

    // ---------------- stage 1: select ----------------
    logic [NUM_LAYERS-1:0] act;
    logic [IDX_W-1:0]      win_idx, und_idx;
    logic                  win_valid, und_valid;
    logic [PIX_W-1:0]      win_rgb, und_rgb;

    // Active layers; a fully faded-out overlay is treated as absent.
    always_comb begin
        act = rq_flag & layer_en;
        if (alpha == '0) act[OVL_IDX] = 1'b0;
    end

    layer_prio_enc #(
        .NUM_LAYERS(NUM_LAYERS)
    ) u_prio (
        .act       (act),
        .win       (win_idx),
        .win_valid (win_valid),
        .und       (und_idx),
        .und_valid (und_valid)
    );

    assign win_rgb = win_valid ? rgb_in[win_idx*PIX_W +: PIX_W] : '0;
    assign und_rgb = und_valid ? rgb_in[und_idx*PIX_W +: PIX_W] : '0;

    logic [PIX_W-1:0] s1_win_rgb, s1_und_rgb;
    logic             s1_win_ovl, s1_any, s1_valid, s1_hs, s1_vs;
    logic [ALPHA_W:0] s1_alpha;

    // Stage-1 register: selected colours, alpha snapshot and syncs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_win_rgb <= '0;
            s1_und_rgb <= '0;
            s1_win_ovl <= 1'b0;
            s1_any     <= 1'b0;
            s1_valid   <= 1'b0;
            s1_hs      <= 1'b0;
            s1_vs      <= 1'b0;
            s1_alpha   <= '0;
        end else begin
            s1_win_rgb <= win_rgb;
            s1_und_rgb <= und_rgb;
            s1_win_ovl <= win_valid && (win_idx == IDX_W'(OVL_IDX));
            s1_any     <= win_valid;
            s1_valid   <= pix_valid_in;
            s1_hs      <= hs_in;
            s1_vs      <= vs_in;
            s1_alpha   <= alpha;
        end
    end

    // ---------------- stage 2: blend ----------------
    logic [PIX_W-1:0]   mix_rgb;
    logic [COLOR_W-1:0] ovl_c, und_c;
    logic [MIX_W-1:0]   acc;

    // Per-channel linear blend of overlay over underlay, truncating.
    always_comb begin
        mix_rgb = '0;
        ovl_c   = '0;
        und_c   = '0;
        acc     = '0;
        for (int unsigned c = 0; c < 3; c++) begin
            ovl_c = COLOR_W'(chan(CHAN_IN_W'(s1_win_rgb), c, COLOR_W));
            und_c = COLOR_W'(chan(CHAN_IN_W'(s1_und_rgb), c, COLOR_W));
            acc   = MIX_W'(ovl_c) * MIX_W'(s1_alpha)
                  + MIX_W'(und_c) * MIX_W'(ALPHA_MAX - s1_alpha);
            mix_rgb[c*COLOR_W +: COLOR_W] = COLOR_W'(acc >> ALPHA_W);
        end
    end

    // Output register: blank, blended or winning colour plus delayed syncs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out       <= '0;
            pix_valid_out <= 1'b0;
            hs_out        <= 1'b0;
            vs_out        <= 1'b0;
        end else begin
            if (!s1_valid || !s1_any)
                rgb_out <= '0;
            else if (s1_win_ovl && s1_alpha != ALPHA_MAX)
                rgb_out <= mix_rgb;
            else
                rgb_out <= s1_win_rgb;
            pix_valid_out <= s1_valid;
            hs_out        <= s1_hs;
            vs_out        <= s1_vs;
        end
    end

endmodule

// File: tb/tb_layer_mixer.sv
// Self-checking bench for layer_mixer: directed scenarios plus randomized
// traffic, compared against a behavioural model of priority, blend and fade.
module tb_layer_mixer;

    localparam int NL   = 5;
    localparam int CW   = 8;
    localparam int OVL  = 3;
    localparam int AW   = 4;
    localparam int FD   = 2;
    localparam int AMAX = 1 << AW;
    localparam int PW   = 3 * CW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame_start = 1'b0;
    logic             pix_valid_in = 1'b0;
    logic             hs_in = 1'b0;
    logic             vs_in = 1'b0;
    logic             ovl_req = 1'b0;
    logic [NL-1:0]    rq_flag = '0;
    logic [NL-1:0]    layer_en = '0;
    logic [NL*PW-1:0] rgb_in = '0;
    logic [PW-1:0]    rgb_out;
    logic             pix_valid_out, hs_out, vs_out, fade_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    layer_mixer #(
        .NUM_LAYERS(NL),
        .COLOR_W   (CW),
        .OVL_IDX   (OVL),
        .ALPHA_W   (AW),
        .FADE_DIV  (FD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .pix_valid_in (pix_valid_in),
        .hs_in        (hs_in),
        .vs_in        (vs_in),
        .rq_flag      (rq_flag),
        .layer_en     (layer_en),
        .rgb_in       (rgb_in),
        .ovl_req      (ovl_req),
        .rgb_out      (rgb_out),
        .pix_valid_out(pix_valid_out),
        .hs_out       (hs_out),
        .vs_out       (vs_out),
        .fade_busy    (fade_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [PW-1:0] rgb;
        logic          pv;
        logic          hs;
        logic          vs;
    } exp_t;

    int   m_alpha;
    int   m_cnt;
    bit   m_moving;
    bit   m_up;
    exp_t prev_exp;

    task automatic model_reset();
        m_alpha  = 0;
        m_cnt    = 0;
        m_moving = 0;
        m_up     = 0;
        prev_exp = '{default: '0};
    endtask

    task automatic model_tick();
        m_cnt++;
        if (m_cnt == FD) begin
            m_cnt = 0;
            m_alpha += m_up ? 1 : -1;
            if (m_alpha == 0 || m_alpha == AMAX) m_moving = 0;
        end
    endtask

    task automatic model_frame(input bit r);
        if (!m_moving) begin
            if ((r && m_alpha == 0) || (!r && m_alpha == AMAX)) begin
                m_moving = 1;
                m_up     = r;
                m_cnt    = 0;
                model_tick();
            end
        end else if (r != m_up) begin
            m_up  = r;
            m_cnt = 0;
            if ((r && m_alpha == AMAX) || (!r && m_alpha == 0)) m_moving = 0;
        end else begin
            model_tick();
        end
    endtask

    function automatic logic [PW-1:0] model_pixel();
        logic [NL-1:0] act;
        int            found[$];
        logic [PW-1:0] o, u, r;
        act = rq_flag & layer_en;
        if (m_alpha == 0) act[OVL] = 1'b0;
        if (!pix_valid_in || act == '0) return '0;
        for (int i = NL - 1; i >= 0; i--)
            if (act[i]) found.push_back(i);
        o = rgb_in[found[0]*PW +: PW];
        if (found[0] != OVL || m_alpha == AMAX) return o;
        u = (found.size() > 1) ? rgb_in[found[1]*PW +: PW] : '0;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            int a;
            int b;
            a = int'(o[c*CW +: CW]);
            b = int'(u[c*CW +: CW]);
            r[c*CW +: CW] = CW'((a * m_alpha + b * (AMAX - m_alpha)) / AMAX);
        end
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_layer(input int i, input logic [PW-1:0] c);
        rgb_in[i*PW +: PW] = c;
    endtask

    task automatic rand_inputs();
        rq_flag      = NL'($urandom);
        layer_en     = NL'($urandom);
        for (int i = 0; i < NL; i++) set_layer(i, PW'($urandom));
        pix_valid_in = 1'($urandom);
        hs_in        = 1'($urandom);
        vs_in        = 1'($urandom);
    endtask

    // One clock: apply frame_start/ovl_req, advance model, check the output
    // against the expectation for the previous cycle's inputs.
    task automatic cycle(input bit fs, input bit req);
        exp_t e;
        frame_start = fs;
        ovl_req     = fs ? req : 1'($urandom);
        e.rgb = model_pixel();
        e.pv  = pix_valid_in;
        e.hs  = hs_in;
        e.vs  = vs_in;
        @(posedge clk);
        if (fs) model_frame(req);
        #1;
        check("rgb_out", 32'(rgb_out), 32'(prev_exp.rgb));
        check("pix_valid_out", 32'(pix_valid_out), 32'(prev_exp.pv));
        check("hs_out", 32'(hs_out), 32'(prev_exp.hs));
        check("vs_out", 32'(vs_out), 32'(prev_exp.vs));
        check("fade_busy", 32'(fade_busy), 32'(m_moving));
        prev_exp = e;
    endtask

    task automatic hold_reset(input int n);
        rst_n = 1'b0;
        for (int k = 0; k < n; k++) begin
            rand_inputs();
            frame_start = 1'($urandom);
            ovl_req     = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst_rgb", 32'(rgb_out), 32'd0);
            check("rst_pv", 32'(pix_valid_out), 32'd0);
            check("rst_hs", 32'(hs_out), 32'd0);
            check("rst_vs", 32'(vs_out), 32'd0);
            check("rst_busy", 32'(fade_busy), 32'd0);
        end
        model_reset();
        rst_n = 1'b1;
    endtask

    // Six-pixel frame: overlay over blue, overlay alone, top layer over overlay.
    task automatic run_frame(input bit req);
        for (int j = 0; j < 6; j++) begin
            case (j)
                2:       rq_flag = 5'b01000;
                3:       rq_flag = 5'b11000;
                default: rq_flag = 5'b01001;
            endcase
            layer_en     = '1;
            pix_valid_in = 1'b1;
            hs_in        = 1'($urandom);
            vs_in        = 1'($urandom);
            cycle(j == 0, req);
            if (m_alpha == 8) begin
                if (j == 3) check("blend_black", 32'(rgb_out), 32'h7F0000);
                if (j == 4) check("top_over_ovl", 32'(rgb_out), 32'h00FF00);
                if (j == 5) check("blend_half", 32'(rgb_out), 32'h7F007F);
            end
        end
    endtask

    initial begin
        int  frames;
        bit  rreq;
        bit  fs;

        model_reset();

        // Reset with random inputs; then the flushed pipeline drains zeros.
        hold_reset(5);

        // Priority and enable mask.
        rq_flag      = 5'b00111;
        layer_en     = '1;
        pix_valid_in = 1'b1;
        set_layer(1, 24'h112233);
        set_layer(2, 24'hAABBCC);
        cycle(0, 0);
        cycle(0, 0);
        check("prio_top", 32'(rgb_out), 32'hAABBCC);
        layer_en[2] = 1'b0;
        cycle(0, 0);
        cycle(0, 0);
        check("prio_masked", 32'(rgb_out), 32'h112233);
        rq_flag = '0;
        cycle(0, 0);
        cycle(0, 0);
        check("prio_none", 32'(rgb_out), 32'h000000);

        // Fade in from OFF to ON.
        set_layer(0, 24'h0000FF);
        set_layer(3, 24'hFF0000);
        set_layer(4, 24'h00FF00);
        frames = 0;
        do begin
            run_frame(1);
            frames++;
        end while (fade_busy && frames < 40);
        check("fade_in_len", 32'(frames), 32'd32);

        // Overlay fully on: top layer still wins, overlay shown unblended.
        run_frame(1);
        run_frame(1);

        // Full fade out.
        frames = 0;
        do begin
            run_frame(0);
            frames++;
        end while (fade_busy && frames < 40);
        check("fade_out_len", 32'(frames), 32'd32);

        // Reversal at alpha 5.
        frames = 0;
        while (m_alpha != 5 && frames < 20) begin
            run_frame(1);
            frames++;
        end
        check("rev_reach5", 32'(frames), 32'd10);
        frames = 0;
        do begin
            run_frame(0);
            frames++;
        end while (fade_busy && frames < 20);
        check("rev_len", 32'(frames), 32'd11);

        // Random traffic with occasional frame starts and request flips,
        // including an asynchronous reset in the middle.
        rreq = 1'b0;
        for (int n = 0; n < 900; n++) begin
            if (n == 450) hold_reset(3);
            rand_inputs();
            fs = ($urandom_range(0, 7) == 0);
            if (fs && $urandom_range(0, 15) == 0) rreq = ~rreq;
            cycle(fs, rreq);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
